// File: rtl/two_phase_bus_arbiter_if.sv
// Upstream and downstream two-phase handshake bundle for the round-robin bus arbiter.
// The slave modport is the arbiter's view; master is the requester/bus-slave environment.
interface two_phase_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PKT_W = 32
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       in_req;
  logic [N_REQ-1:0]       in_ack;
  logic [N_REQ*PKT_W-1:0] in_data;
  logic                   out_req;
  logic                   out_ack;
  logic [PKT_W-1:0]       out_data;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, grant_id, busy, timeout_err
  );

  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/two_phase_bus_arbiter.sv
// Round-robin arbiter sharing one downstream two-phase link among N_REQ two-phase requesters.
// The upstream ack toggles only after the downstream ack returns, followed by a release bubble.
module two_phase_bus_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PKT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  two_phase_bus_arbiter_if.slave    bus
);
  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   in_ack_q, in_ack_d;
  logic               out_req_q, out_req_d;
  logic [PKT_W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     last_q, last_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   pending;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     sel;
  logic               found;
  logic [PKT_W-1:0]   pkt [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign pkt[g] = bus.in_data[g*PKT_W +: PKT_W];
  end

  always_comb begin
    state_d    = state_q;
    in_ack_d   = in_ack_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    busy_d     = busy_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cand       = '0;
    sel        = '0;
    found      = 1'b0;

    // Round-robin search starting just after the most recent grant.
    pending = bus.in_req ^ in_ack_q;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IDW'((int'(last_q) + k) % int'(N_REQ));
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          out_data_d = pkt[sel];
          out_req_d  = ~out_req_q;
          grant_d    = sel;
          last_d     = sel;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.out_ack == out_req_q) begin
          in_ack_d[grant_q] = ~in_ack_q[grant_q];
          state_d           = RELEASE;
        end else begin
          // Watchdog saturates at the limit; the error is sticky and the transfer keeps waiting.
          if (cnt_q != TO_CNT) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TO_CNT) err_d = 1'b1;
        end
      end
      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ack_q   <= '0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      grant_q    <= '0;
      last_q     <= IDW'(N_REQ - 1);
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ack      = in_ack_q;
  assign bus.out_req     = out_req_q;
  assign bus.out_data    = out_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_two_phase_bus_arbiter.sv
// Directed bench for two_phase_bus_arbiter: a cycle table for grant order and holding,
// plus hand sequences for the watchdog, mid-transfer reset and packet capture.
module tb_two_phase_bus_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  two_phase_bus_arbiter_if #(.N_REQ(4), .PKT_W(32)) bus ();

  two_phase_bus_arbiter #(.N_REQ(4), .PKT_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic        exp_oreq;
    logic [3:0]  exp_iack;
    logic [1:0]  exp_gid;
    logic        exp_busy;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    //            rst req     ack oreq iack    gid   busy data
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 32'hA1053C7E};
    vecs[2]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 32'hA1053C7E};
    vecs[3]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 32'hA1053C7E};
    vecs[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h00000000};
    vecs[5]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 32'h11111111};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 32'h11111111};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 32'h11111111};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd1, 1'b1, 32'h22222222};
    vecs[9]  = '{1'b0, 4'b1110, 1'b0, 1'b0, 4'b0011, 2'd1, 1'b1, 32'h22222222};
    vecs[10] = '{1'b0, 4'b1110, 1'b0, 1'b0, 4'b0011, 2'd1, 1'b0, 32'h22222222};
    vecs[11] = '{1'b0, 4'b1110, 1'b0, 1'b1, 4'b0011, 2'd2, 1'b1, 32'hA1053C7E};
    vecs[12] = '{1'b0, 4'b1110, 1'b1, 1'b1, 4'b0111, 2'd2, 1'b1, 32'hA1053C7E};
    vecs[13] = '{1'b0, 4'b1110, 1'b1, 1'b1, 4'b0111, 2'd2, 1'b0, 32'hA1053C7E};
    vecs[14] = '{1'b0, 4'b1110, 1'b1, 1'b0, 4'b0111, 2'd3, 1'b1, 32'h44444444};
    vecs[15] = '{1'b0, 4'b1110, 1'b0, 1'b0, 4'b1111, 2'd3, 1'b1, 32'h44444444};
    vecs[16] = '{1'b0, 4'b1110, 1'b0, 1'b0, 4'b1111, 2'd3, 1'b0, 32'h44444444};
    vecs[17] = '{1'b0, 4'b1110, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, 32'h11111111};
    vecs[18] = '{1'b0, 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 32'h11111111};
    vecs[19] = '{1'b0, 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 32'h11111111};
    vecs[20] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h00000000};
    vecs[21] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1, 32'h44444444};
    vecs[22] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1, 32'h44444444};
    vecs[23] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 32'h44444444};
    vecs[24] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 32'h44444444};
    vecs[25] = '{1'b0, 4'b1010, 1'b1, 1'b0, 4'b1000, 2'd1, 1'b1, 32'h22222222};
    vecs[26] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b1, 32'h22222222};
    vecs[27] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b0, 32'h22222222};

    rst         = 1'b1;
    bus.in_req  = '0;
    bus.out_ack = 1'b0;
    bus.in_data = {32'h44444444, 32'hA1053C7E, 32'h22222222, 32'h11111111};
    step();

    for (int i = 0; i < NV; i++) begin
      rst         = vecs[i].rst;
      bus.in_req  = vecs[i].req;
      bus.out_ack = vecs[i].ack;
      step();
      chk($sformatf("v%0d_out_req", i),  32'(bus.out_req),     32'(vecs[i].exp_oreq));
      chk($sformatf("v%0d_in_ack", i),   32'(bus.in_ack),      32'(vecs[i].exp_iack));
      chk($sformatf("v%0d_grant_id", i), 32'(bus.grant_id),    32'(vecs[i].exp_gid));
      chk($sformatf("v%0d_busy", i),     32'(bus.busy),        32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_out_data", i), bus.out_data,         vecs[i].exp_data);
      chk($sformatf("v%0d_tmo_err", i),  32'(bus.timeout_err), 32'd0);
    end

    // Watchdog: ack withheld for 20 cycles after granting requester 0.
    rst = 1'b1; bus.in_req = '0; bus.out_ack = 1'b0;
    step();
    rst = 1'b0; bus.in_req = 4'b0001;
    step();
    chk("tmo_grant_oreq", 32'(bus.out_req), 32'd1);
    chk("tmo_grant_gid", 32'(bus.grant_id), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("tmo_err_c%0d", k), 32'(bus.timeout_err), (k >= 8) ? 32'd1 : 32'd0);
    end
    chk("tmo_no_ack_yet", 32'(bus.in_ack), 32'd0);
    bus.out_ack = 1'b1;
    step();
    chk("tmo_late_ack", 32'(bus.in_ack), 32'b0001);
    chk("tmo_err_sticky1", 32'(bus.timeout_err), 32'd1);
    step();
    chk("tmo_release_busy", 32'(bus.busy), 32'd0);
    chk("tmo_err_sticky2", 32'(bus.timeout_err), 32'd1);

    // Mid-transfer reset while granting requester 2.
    bus.in_req = 4'b0101;
    step();
    chk("mid_grant_gid", 32'(bus.grant_id), 32'd2);
    chk("mid_grant_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1; bus.in_req = '0; bus.out_ack = 1'b0;
    step();
    chk("mid_rst_oreq", 32'(bus.out_req), 32'd0);
    chk("mid_rst_iack", 32'(bus.in_ack), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_gid", 32'(bus.grant_id), 32'd0);
    chk("mid_rst_err", 32'(bus.timeout_err), 32'd0);
    chk("mid_rst_data", bus.out_data, 32'd0);
    rst = 1'b0; bus.in_req = 4'b1111;
    step();
    chk("mid_first_gid", 32'(bus.grant_id), 32'd0);
    chk("mid_first_oreq", 32'(bus.out_req), 32'd1);

    // Packet is captured at grant; later in_data changes are not forwarded.
    rst = 1'b1; bus.in_req = '0; bus.out_ack = 1'b0;
    step();
    rst = 1'b0; bus.in_req = 4'b0010;
    step();
    chk("cap_gid", 32'(bus.grant_id), 32'd1);
    chk("cap_data0", bus.out_data, 32'h22222222);
    bus.in_data[32 +: 32] = 32'hFFFFFFFF;
    step();
    chk("cap_data1", bus.out_data, 32'h22222222);
    bus.out_ack = 1'b1;
    step();
    chk("cap_iack", 32'(bus.in_ack), 32'b0010);
    step();
    chk("cap_data2", bus.out_data, 32'h22222222);
    bus.in_req = 4'b0000;
    step();
    chk("cap_regrant_oreq", 32'(bus.out_req), 32'd0);
    chk("cap_regrant_data", bus.out_data, 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/two_phase_bus_arbiter.md
Name: two_phase_bus_arbiter

Overview:
- Round-robin arbiter that shares one downstream two-phase (toggle) handshake link among N upstream requesters.
- Each requester offers a 32-bit packet (head, dst, pay, crc; 8 bits each) on its own two-phase req/ack pair.
- The arbiter grants one requester and forwards its packet downstream. It completes the upstream handshake only after the downstream acknowledges.
- It sits between the serdes-side senders and the shared bus slave.

Parameters:
- N_REQ, 4, number of upstream requesters (2..8).
- PKT_W, 32, packet width (head/dst/pay/crc, 8 bits each, head in MSBs).
- TIMEOUT, 255, cycles to wait for the downstream ack before flagging an error (1..255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_req  input  N_REQ  per-requester two-phase request phase.
- in_ack  output  N_REQ  per-requester two-phase acknowledge phase.
- in_data  input  N_REQ*PKT_W  packet of requester i in bits [i*PKT_W +: PKT_W].
- out_req  output  1  downstream two-phase request phase.
- out_ack  input  1  downstream two-phase acknowledge phase.
- out_data  output  PKT_W  packet presented downstream.
- grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
- busy  output  1  high while a transfer is in flight.
- timeout_err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - in_ack=0, out_req=0, out_data=0, grant_id=0, busy=0, timeout_err=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - Watchdog counter=0; FSM in IDLE.
- Pending rule: requester i is pending when in_req[i] != in_ack[i]. The downstream is complete when out_ack == out_req.
- FSM states: IDLE, WAIT_ACK, RELEASE.
- IDLE:
  - If any requester is pending, select the first pending index searching last+1, last+2, … modulo N_REQ.
  - On the same edge: out_data <= selected packet, out_req <= ~out_req, grant_id <= index, last <= index, busy <= 1, counter <= 0; go to WAIT_ACK.
  - Latency: out_req toggles on the first edge at which a pending request is visible in IDLE.
  - If nothing is pending, all outputs hold.
- WAIT_ACK:
  - out_data and out_req are held stable.
  - If out_ack == out_req: in_ack[grant_id] <= ~in_ack[grant_id]; go to RELEASE.
  - Otherwise counter increments. When counter reaches TIMEOUT, timeout_err <= 1 and the FSM stays in WAIT_ACK. There is no abort; the transfer completes whenever the ack arrives.
- RELEASE:
  - busy <= 0; go to IDLE.
  - This bubble cycle guarantees the upstream sees its ack toggle before re-arbitration.
  - Minimum spacing between grants is 3 cycles when out_ack returns in the cycle after the out_req toggle.
- Round-robin fairness: the most recently granted requester has lowest priority at the next arbitration. No requester waits more than N_REQ-1 grants.
- Simultaneous events:
  - Multiple new requests in one cycle are resolved by round-robin only.
  - Requests arriving during WAIT_ACK/RELEASE are held pending; none are lost, because two-phase state persists.
  - An in_req toggle from the granted requester before its ack is a protocol violation. The arbiter ignores it (pending is re-evaluated only in IDLE).
- Data: the packet is captured only at grant. Later changes to in_data are not forwarded. The packet is passed unmodified; crc is not checked here.
- Phase wrap: the toggle phases are 1-bit and wrap naturally; no counters on phase.
- Reset mid-transfer: all phases return to 0 regardless of state. Requesters and the downstream must be reset by the same rst. The in-flight packet is discarded.

Test Plan:
- Single request: after reset, requester 2 toggles in_req[2]=1 with in_data[2]=32'hA1_05_3C_7E → next edge out_req=1, out_data=32'hA1053C7E, grant_id=2, busy=1. Drive out_ack=1 → next edge in_ack[2]=1; one cycle later busy=0.
- Round-robin: all 4 requesters toggle in the same cycle, with out_ack echoing out_req one cycle later → grant order 0,1,2,3. Requester 0 re-requests during the grant to 1 → order continues 2,3,0.
- Held requests: requester 1 toggles during WAIT_ACK for requester 3 → no change to out_data until RELEASE completes. Requester 1 is then granted and out_req toggles back to 0 (second phase).
- Timeout: with TIMEOUT=8, grant requester 0 and withhold out_ack for 20 cycles → timeout_err=1 at cycle 8 after the grant and stays 1. Then toggle out_ack → in_ack[0] toggles and timeout_err remains 1 until rst.
- Mid-transfer reset: assert rst in WAIT_ACK → next edge out_req=0, in_ack=0, busy=0, grant_id=0. The first grant after reset goes to requester 0 when all requesters are pending.
- Data capture: change in_data[1] to 32'hFFFFFFFF after the grant of 1 → out_data keeps the captured value until the next grant.
